mem_arbiter: RTL

Two-requester arbiter and sequencer for the CPU's single shared memory port. It sits between the core's instruction-fetch and load/store units and the `memory` block, replacing the direct `memRead`/`memWrite`/`memAddr`/`memDataIn`/`memDataOut` connection. It serialises accesses one at a time, drives a one-cycle memory strobe, and waits the memory's fixed read latency. It returns data with a `done` pulse, using round-robin on conflict.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    localparam int MAX_LATENCY = 4;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; the caller owns last_grant.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_fetch,
    input  logic req_data,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req_fetch | req_data;
        grant = GNT_FETCH;
        if (req_fetch && req_data) begin
            // On conflict, favour whichever port was not served last.
            grant = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (req_data) begin
            grant = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto the single memory port,
// strobing once per access and waiting the memory's fixed read latency.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic        iDone,
    output logic [31:0] iRdata,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic        dDone,
    output logic [31:0] dRdata,
    output logic        err,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memDataIn,
    input  logic [31:0] memDataOut
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               gnt_q, gnt_d;
    logic               we_q, we_d;
    logic               mis_q, mis_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_data_in_q, mem_data_in_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;

    logic               pick_grant;
    logic               pick_valid;
    logic [31:0]        sel_addr;
    logic               sel_mis;

    rr_pick2 u_pick (
        .req_fetch  (iReq),
        .req_data   (dReq),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    assign sel_addr = (pick_grant == GNT_DATA) ? dAddr : iAddr;
    assign sel_mis  = |sel_addr[1:0];

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            last_grant_q  <= GNT_FETCH;
            gnt_q         <= GNT_FETCH;
            we_q          <= 1'b0;
            mis_q         <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            gnt_q         <= gnt_d;
            we_q          <= we_d;
            mis_q         <= mis_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_valid) state_d = sel_mis ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (cnt_q == ONE) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        we_d          = we_q;
        mis_d         = mis_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    last_grant_d = pick_grant;
                    gnt_d        = pick_grant;
                    we_d         = (pick_grant == GNT_DATA) && dWe;
                    mis_d        = sel_mis;
                    if (!sel_mis) begin
                        mem_addr_d = sel_addr;
                        if (pick_grant == GNT_DATA && dWe) mem_data_in_d = dWdata;
                    end else if (pick_grant == GNT_DATA) begin
                        d_rdata_d = '0;
                    end else begin
                        i_rdata_d = '0;
                    end
                end
            end
            ST_ISSUE: cnt_d = LAT;
            ST_WAIT: begin
                cnt_d = cnt_q - ONE;
                // Final wait cycle: memory output is valid now, writes just time out.
                if (cnt_q == ONE && !we_q) begin
                    if (gnt_q == GNT_DATA) d_rdata_d = memDataOut;
                    else                   i_rdata_d = memDataOut;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        memRead   = (state_q == ST_ISSUE) && !we_q;
        memWrite  = (state_q == ST_ISSUE) && we_q;
        iDone     = (state_q == ST_DONE) && (gnt_q == GNT_FETCH);
        dDone     = (state_q == ST_DONE) && (gnt_q == GNT_DATA);
        err       = (state_q == ST_DONE) && mis_q;
        memAddr   = mem_addr_q;
        memDataIn = mem_data_in_q;
        iRdata    = i_rdata_q;
        dRdata    = d_rdata_q;
    end

endmodule
